// File: rtl/ddr3_ctrl_pkg.sv
// Shared definitions for the DDR3 frame reader: FSM state encoding and
// the Avalon burst-size encoding.
package ddr3_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ISSUE    = 2'd1,
        ST_THROTTLE = 2'd2,
        ST_DONE     = 2'd3
    } rd_state_e;

    localparam int unsigned AVL_SIZE_W = 3;

    // Burst length as carried on avl_size; a length of 8 does not fit in
    // three bits and encodes as 3'b000.
    function automatic logic [AVL_SIZE_W-1:0] avl_size_enc(input int unsigned burst_len);
        return burst_len[AVL_SIZE_W-1:0];
    endfunction

endpackage

// File: rtl/ddr3_frame_reader_if.sv
// Avalon-MM read-request bundle between the frame reader (master) and the
// DDR3 controller (slave). ddr3_frame_reader itself exposes these as flat
// ports so existing instantiations keep working.
interface ddr3_frame_reader_if
    import ddr3_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 26
) ();
    logic                  avl_ready;
    logic                  avl_read_req;
    logic                  avl_burstbegin;
    logic [ADDR_W-1:0]     avl_addr;
    logic [AVL_SIZE_W-1:0] avl_size;

    modport master (
        input  avl_ready,
        output avl_read_req, avl_burstbegin, avl_addr, avl_size
    );

    modport slave (
        output avl_ready,
        input  avl_read_req, avl_burstbegin, avl_addr, avl_size
    );
endinterface

// File: rtl/rr_buffer_select.sv
// Combinational round-robin search: first set bit of mask_i starting at
// start_i and wrapping modulo N.
module rr_buffer_select #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o
);
    logic [IDX_W-1:0] probe;

    // Walk the buffers in wrap-around order, keep the first candidate.
    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        probe   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            probe = IDX_W'((32'(start_i) + i) % N);
            if (!valid_o && mask_i[probe]) begin
                valid_o = 1'b1;
                index_o = probe;
            end
        end
    end
endmodule

// File: rtl/ddr3_frame_reader.sv
// Reads complete frames out of a ring of DDR3 frame buffers as a sequence of
// fixed-length Avalon read bursts, throttled by the downstream FIFO.
module ddr3_frame_reader
    import ddr3_ctrl_pkg::*;
#(
    parameter int unsigned IMAGE_WIDTH      = 1280,
    parameter int unsigned IMAGE_HEIGHT     = 1024,
    parameter int unsigned NUM_BUFFERS      = 3,
    parameter int unsigned PIXELS_PER_BURST = 16,
    parameter int unsigned BURST_LEN        = 4,
    parameter int unsigned ADDR_W           = 26
) (
    input  logic                             ddr3_clk,
    input  logic                             ddr3_reset_n,
    input  logic                             enable,
    input  logic [NUM_BUFFERS-1:0]           buf_full,
    input  logic [NUM_BUFFERS*ADDR_W-1:0]    buf_base,
    output logic [NUM_BUFFERS-1:0]           buf_release,
    input  logic                             data_fifo_almost_full,
    input  logic                             avl_ready,
    output logic                             avl_read_req,
    output logic                             avl_burstbegin,
    output logic [ADDR_W-1:0]                avl_addr,
    output logic [AVL_SIZE_W-1:0]            avl_size,
    output logic [$clog2(NUM_BUFFERS)-1:0]   cur_buf,
    output logic                             frame_start,
    output logic                             frame_done
);
    localparam int unsigned NBURSTS    = IMAGE_WIDTH * IMAGE_HEIGHT / PIXELS_PER_BURST;
    localparam int unsigned CNT_W      = (NBURSTS > 1) ? $clog2(NBURSTS) : 1;
    localparam int unsigned BUF_W      = $clog2(NUM_BUFFERS);
    localparam logic [CNT_W-1:0]  LAST_BURST = CNT_W'(NBURSTS - 1);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BURST_LEN);

    rd_state_e               state_q;
    logic                    req_q, bb_q, fs_q, fd_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [BUF_W-1:0]        cur_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [NUM_BUFFERS-1:0]  rel_q;
    // owned_q: cur_q holds a frame we read and have not released yet.
    // pend_q/pend_idx_q: buffer chosen in DONE, launched from IDLE.
    logic                    owned_q, pend_q;
    logic [BUF_W-1:0]        pend_idx_q;

    logic [ADDR_W-1:0]       base_arr [NUM_BUFFERS];
    logic [ADDR_W-1:0]       addr_d;
    logic [BUF_W-1:0]        cur_inc, srch_start, sel_idx, launch_idx;
    logic [NUM_BUFFERS-1:0]  cur_onehot, srch_mask, launch_rel;
    logic                    sel_valid, repeat_ok, launch;

    for (genvar g = 0; g < NUM_BUFFERS; g++) begin : g_base
        assign base_arr[g] = buf_base[g*ADDR_W +: ADDR_W];
    end

    assign addr_d     = addr_q + ADDR_STEP;
    assign cur_onehot = NUM_BUFFERS'(1) << cur_q;
    assign cur_inc    = (cur_q == BUF_W'(NUM_BUFFERS - 1)) ? '0 : cur_q + BUF_W'(1);
    // Until the first frame is read nothing is owned: search everything from 0.
    assign srch_mask  = buf_full & ~(owned_q ? cur_onehot : '0);
    assign srch_start = owned_q ? cur_inc : cur_q;
    assign repeat_ok  = owned_q && buf_full[cur_q];

    rr_buffer_select #(
        .N     (NUM_BUFFERS),
        .IDX_W (BUF_W)
    ) u_sel (
        .mask_i  (srch_mask),
        .start_i (srch_start),
        .valid_o (sel_valid),
        .index_o (sel_idx)
    );

    // Frame launch decision in IDLE: pending choice from DONE first, else a
    // live search (a late-filling buffer still releases the one we hold).
    always_comb begin
        launch     = 1'b0;
        launch_idx = cur_q;
        launch_rel = '0;
        if (state_q == ST_IDLE && enable) begin
            if (pend_q) begin
                launch     = 1'b1;
                launch_idx = pend_idx_q;
            end else if (sel_valid) begin
                launch     = 1'b1;
                launch_idx = sel_idx;
                launch_rel = owned_q ? cur_onehot : '0;
            end else if (repeat_ok) begin
                launch     = 1'b1;
            end
        end
    end

    // Read FSM with registered Avalon, status and release outputs.
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state_q    <= ST_IDLE;
            req_q      <= 1'b0;
            bb_q       <= 1'b0;
            fs_q       <= 1'b0;
            fd_q       <= 1'b0;
            addr_q     <= '0;
            cur_q      <= '0;
            cnt_q      <= '0;
            rel_q      <= '0;
            owned_q    <= 1'b0;
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
        end else begin
            fs_q  <= 1'b0;
            fd_q  <= 1'b0;
            rel_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (launch) begin
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b1;
                        bb_q    <= 1'b1;
                        fs_q    <= 1'b1;
                        addr_q  <= base_arr[launch_idx];
                        cur_q   <= launch_idx;
                        cnt_q   <= '0;
                        rel_q   <= launch_rel;
                        owned_q <= 1'b1;
                        pend_q  <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    bb_q <= 1'b0;
                    if (avl_ready) begin
                        if (cnt_q == LAST_BURST) begin
                            state_q <= ST_DONE;
                            req_q   <= 1'b0;
                            fd_q    <= 1'b1;
                        end else begin
                            cnt_q  <= cnt_q + CNT_W'(1);
                            addr_q <= addr_d;
                            if (!data_fifo_almost_full) begin
                                bb_q <= 1'b1;
                            end else begin
                                state_q <= ST_THROTTLE;
                                req_q   <= 1'b0;
                            end
                        end
                    end
                end
                ST_THROTTLE: begin
                    if (!data_fifo_almost_full) begin
                        state_q <= ST_ISSUE;
                        req_q   <= 1'b1;
                        bb_q    <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (sel_valid) begin
                        rel_q      <= cur_onehot;
                        owned_q    <= 1'b0;
                        pend_q     <= 1'b1;
                        pend_idx_q <= sel_idx;
                    end else if (repeat_ok) begin
                        pend_q     <= 1'b1;
                        pend_idx_q <= cur_q;
                    end else begin
                        pend_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign avl_read_req   = req_q;
    assign avl_burstbegin = bb_q;
    assign avl_addr       = addr_q;
    assign avl_size       = avl_size_enc(BURST_LEN);
    assign cur_buf        = cur_q;
    assign frame_start    = fs_q;
    assign frame_done     = fd_q;
    assign buf_release    = rel_q;
endmodule

// File: tb/tb_ddr3_frame_reader.sv
// Bench for ddr3_frame_reader: 16x4 image, 4 bursts of 4 beats per frame,
// three buffers.
module tb_ddr3_frame_reader;
    localparam int NB = 4;
    localparam int BL = 4;
    localparam logic [25:0] BASE0 = 26'h0000100;
    localparam logic [25:0] BASE1 = 26'h0002000;
    localparam logic [25:0] BASE2 = 26'h3FFFFF8;

    logic        clk = 1'b0;
    logic        rst_n, enable, af;
    logic [2:0]  buf_full, buf_release;
    logic [77:0] buf_base;
    logic [1:0]  cur_buf;
    logic        fs, fd;

    ddr3_frame_reader_if #(.ADDR_W(26)) avl ();

    ddr3_frame_reader #(
        .IMAGE_WIDTH      (16),
        .IMAGE_HEIGHT     (4),
        .NUM_BUFFERS      (3),
        .PIXELS_PER_BURST (16),
        .BURST_LEN        (4),
        .ADDR_W           (26)
    ) dut (
        .ddr3_clk              (clk),
        .ddr3_reset_n          (rst_n),
        .enable                (enable),
        .buf_full              (buf_full),
        .buf_base              (buf_base),
        .buf_release           (buf_release),
        .data_fifo_almost_full (af),
        .avl_ready             (avl.avl_ready),
        .avl_read_req          (avl.avl_read_req),
        .avl_burstbegin        (avl.avl_burstbegin),
        .avl_addr              (avl.avl_addr),
        .avl_size              (avl.avl_size),
        .cur_buf               (cur_buf),
        .frame_start           (fs),
        .frame_done            (fd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic        en, rdy, af;
        logic        req, bb, chk_addr;
        logic [31:0] addr;
        logic        fs, fd;
        logic [2:0]  rel;
    } vec_t;

    vec_t vt[22];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(input logic en, input logic rdy, input logic a_f,
                                 input logic req, input logic bb, input logic ca,
                                 input logic [31:0] addr, input logic f_s, input logic f_d);
        vec_t v;
        v.en = en; v.rdy = rdy; v.af = a_f;
        v.req = req; v.bb = bb; v.chk_addr = ca; v.addr = addr;
        v.fs = f_s; v.fd = f_d; v.rel = 3'b000;
        return v;
    endfunction

    function automatic logic [25:0] base_of(input int b);
        case (b)
            0:       return BASE0;
            1:       return BASE1;
            default: return BASE2;
        endcase
    endfunction

    // Next buffer to read: cur < 0 means nothing held yet (search from 0);
    // otherwise the first full buffer after cur, else cur itself if full.
    function automatic int model_sel(input logic [2:0] full, input int cur);
        if (cur < 0) begin
            for (int i = 0; i < 3; i++) if (full[i]) return i;
            return -1;
        end
        for (int i = 1; i < 3; i++) begin
            int j;
            j = (cur + i) % 3;
            if (full[j]) return j;
        end
        if (full[cur]) return cur;
        return -1;
    endfunction

    task automatic run_until_fs(input string tag, input int bound,
                                output logic [2:0] rel_or, output int n_rel);
        int c;
        rel_or = '0;
        n_rel  = 0;
        c      = 0;
        step();
        while (!fs && c < bound) begin
            if (buf_release != 3'b000) begin
                rel_or |= buf_release;
                n_rel++;
            end
            step();
            c++;
        end
        check({tag, "_start_seen"}, 32'(fs), 32'd1);
    endtask

    task automatic count_until_fd(input string tag, input int bound, output int acc);
        int c;
        acc = 0;
        c   = 0;
        while (!fd && c < bound) begin
            if (avl.avl_read_req && avl.avl_ready) acc++;
            step();
            c++;
        end
        check({tag, "_done_seen"}, 32'(fd), 32'd1);
    endtask

    // random-phase monitor state
    logic        s_req, s_bb, s_fs, s_fd, rdy_r, af_r;
    logic [25:0] s_addr;
    logic [2:0]  s_rel, exp_rel;
    logic [1:0]  s_cur;
    logic        p_req, p_rdy, p_af, p_fd, p_last, have_prev, in_frame;
    logic [25:0] p_addr;
    int          mbuf, mk, frames, exp_buf;

    initial begin
        logic [2:0] rel_or;
        int         n_rel, acc, cnt_req, cnt_fs, cnt_rel;

        vt[0]  = mkv(1,1,0, 0,0,0, 32'h0,   0,0);
        vt[1]  = mkv(1,1,0, 1,1,1, 32'h100, 1,0);
        vt[2]  = mkv(1,1,0, 1,1,1, 32'h104, 0,0);
        vt[3]  = mkv(1,1,0, 1,1,1, 32'h108, 0,0);
        vt[4]  = mkv(1,1,0, 1,1,1, 32'h10C, 0,0);
        vt[5]  = mkv(1,1,0, 0,0,0, 32'h0,   0,1);
        vt[6]  = mkv(1,1,0, 0,0,0, 32'h0,   0,0);
        vt[7]  = mkv(1,1,1, 1,1,1, 32'h100, 1,0);
        vt[8]  = mkv(1,1,1, 0,0,0, 32'h0,   0,0);
        vt[9]  = mkv(1,1,1, 0,0,0, 32'h0,   0,0);
        vt[10] = mkv(1,1,0, 0,0,0, 32'h0,   0,0);
        vt[11] = mkv(1,0,0, 1,1,1, 32'h104, 0,0);
        vt[12] = mkv(1,0,0, 1,0,1, 32'h104, 0,0);
        vt[13] = mkv(1,0,0, 1,0,1, 32'h104, 0,0);
        vt[14] = mkv(1,0,0, 1,0,1, 32'h104, 0,0);
        vt[15] = mkv(1,0,0, 1,0,1, 32'h104, 0,0);
        vt[16] = mkv(1,1,0, 1,0,1, 32'h104, 0,0);
        vt[17] = mkv(1,1,0, 1,1,1, 32'h108, 0,0);
        vt[18] = mkv(0,1,0, 1,1,1, 32'h10C, 0,0);
        vt[19] = mkv(0,1,0, 0,0,0, 32'h0,   0,1);
        vt[20] = mkv(0,1,0, 0,0,0, 32'h0,   0,0);
        vt[21] = mkv(0,1,0, 0,0,0, 32'h0,   0,0);

        rst_n         = 1'b0;
        enable        = 1'b0;
        af            = 1'b0;
        avl.avl_ready = 1'b1;
        buf_full      = 3'b001;
        buf_base      = {BASE2, BASE1, BASE0};
        step();
        step();
        check("rst_req",   32'(avl.avl_read_req),   0);
        check("rst_bb",    32'(avl.avl_burstbegin), 0);
        check("rst_addr",  32'(avl.avl_addr),       0);
        check("rst_cur",   32'(cur_buf),            0);
        check("rst_rel",   32'(buf_release),        0);
        check("rst_fs",    32'(fs),                 0);
        check("rst_fd",    32'(fd),                 0);
        check("avl_size",  32'(avl.avl_size),       4);

        // Clean frame, then a frame with throttle at burst 1 and a stall on burst 2.
        rst_n = 1'b1;
        for (int i = 0; i < 22; i++) begin
            enable        = vt[i].en;
            avl.avl_ready = vt[i].rdy;
            af            = vt[i].af;
            check($sformatf("v%0d_req", i), 32'(avl.avl_read_req),   32'(vt[i].req));
            check($sformatf("v%0d_bb",  i), 32'(avl.avl_burstbegin), 32'(vt[i].bb));
            if (vt[i].chk_addr)
                check($sformatf("v%0d_addr", i), 32'(avl.avl_addr), vt[i].addr);
            check($sformatf("v%0d_fs",  i), 32'(fs),          32'(vt[i].fs));
            check($sformatf("v%0d_fd",  i), 32'(fd),          32'(vt[i].fd));
            check($sformatf("v%0d_rel", i), 32'(buf_release), 32'(vt[i].rel));
            check($sformatf("v%0d_cur", i), 32'(cur_buf),     0);
            step();
        end

        // Release to the next full buffer, then repeat when alone.
        buf_full      = 3'b011;
        enable        = 1'b1;
        avl.avl_ready = 1'b1;
        af            = 1'b0;
        run_until_fs("r30a", 20, rel_or, n_rel);
        check("r30a_cur",   32'(cur_buf), 0);
        check("r30a_nrel",  32'(n_rel),   0);
        run_until_fs("r30b", 30, rel_or, n_rel);
        check("r30b_rel",   32'(rel_or),  32'b001);
        check("r30b_nrel",  32'(n_rel),   1);
        check("r30b_cur",   32'(cur_buf), 1);
        check("r30b_addr",  32'(avl.avl_addr), 32'(BASE1));
        buf_full = 3'b010;
        run_until_fs("r30c", 30, rel_or, n_rel);
        check("r30c_nrel",  32'(n_rel),   0);
        check("r30c_cur",   32'(cur_buf), 1);

        // Disable during burst 1: frame completes, then stays idle.
        enable = 1'b0;
        count_until_fd("r31", 40, acc);
        check("r31_bursts", 32'(acc), NB);
        cnt_req = 0; cnt_fs = 0; cnt_rel = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (avl.avl_read_req)      cnt_req++;
            if (fs)                    cnt_fs++;
            if (buf_release != 3'b000) cnt_rel++;
        end
        check("r31_idle_req", 32'(cnt_req), 0);
        check("r31_idle_fs",  32'(cnt_fs),  0);
        check("r31_idle_rel", 32'(cnt_rel), 0);

        // Reset mid-frame drops the request at once and releases nothing.
        enable = 1'b1;
        run_until_fs("rrst", 20, rel_or, n_rel);
        step();
        step();
        check("pre_rst_req", 32'(avl.avl_read_req), 1);
        rst_n  = 1'b0;
        enable = 1'b0;
        #1;
        check("async_rst_req",  32'(avl.avl_read_req), 0);
        check("async_rst_addr", 32'(avl.avl_addr),     0);
        check("async_rst_cur",  32'(cur_buf),          0);
        cnt_rel = 0; cnt_req = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) rst_n = 1'b1;
            step();
            if (buf_release != 3'b000) cnt_rel++;
            if (avl.avl_read_req)      cnt_req++;
        end
        check("rst_no_rel", 32'(cnt_rel), 0);
        check("rst_no_req", 32'(cnt_req), 0);

        // Randomised ready/throttle against a transaction-level model.
        rst_n = 1'b0;
        step();
        buf_full  = 3'b111;
        rst_n     = 1'b1;
        enable    = 1'b1;
        mbuf      = -1;
        mk        = 0;
        frames    = 0;
        in_frame  = 1'b0;
        have_prev = 1'b0;
        p_req = 0; p_rdy = 0; p_af = 0; p_fd = 0; p_last = 0; p_addr = '0;
        for (int cyc = 0; cyc < 3000 && frames < 8; cyc++) begin
            s_req  = avl.avl_read_req;
            s_bb   = avl.avl_burstbegin;
            s_addr = avl.avl_addr;
            s_fs   = fs;
            s_fd   = fd;
            s_rel  = buf_release;
            s_cur  = cur_buf;
            if (have_prev) begin
                if (p_req && !p_rdy) begin
                    check("hold_req",  32'(s_req),  1);
                    check("hold_addr", 32'(s_addr), 32'(p_addr));
                    check("hold_bb",   32'(s_bb),   0);
                end else if (p_req && p_rdy) begin
                    if (p_last) begin
                        check("last_req", 32'(s_req), 0);
                        check("last_fd",  32'(s_fd),  1);
                    end else begin
                        check("b2b_req", 32'(s_req), 32'(!p_af));
                        if (s_req) check("b2b_bb", 32'(s_bb), 1);
                    end
                end else if (in_frame) begin
                    check("thr_req", 32'(s_req), 32'(!p_af));
                    if (s_req) check("thr_bb", 32'(s_bb), 1);
                end
                exp_rel = p_fd ? 3'(1 << mbuf) : 3'b000;
                check("rnd_rel", 32'(s_rel), 32'(exp_rel));
            end
            if (s_fs) begin
                exp_buf = model_sel(buf_full, mbuf);
                check("rnd_cur",    32'(s_cur), 32'(exp_buf));
                check("rnd_fs_req", 32'(s_req), 1);
                check("rnd_fs_bb",  32'(s_bb),  1);
                mbuf     = exp_buf;
                mk       = 0;
                in_frame = 1'b1;
            end
            rdy_r = ($urandom_range(0, 9) < 7);
            af_r  = ($urandom_range(0, 3) == 0);
            avl.avl_ready = rdy_r;
            af            = af_r;
            p_last = 1'b0;
            if (s_req && rdy_r) begin
                check($sformatf("rnd_addr_b%0d_k%0d", mbuf, mk), 32'(s_addr),
                      32'((32'(base_of(mbuf)) + 32'(mk * BL)) & 32'h03FF_FFFF));
                mk++;
                p_last = (mk == NB);
            end
            if (s_fd) begin
                check("rnd_frame_len", 32'(mk), NB);
                frames++;
                in_frame = 1'b0;
            end
            p_req     = s_req;
            p_rdy     = rdy_r;
            p_af      = af_r;
            p_fd      = s_fd;
            p_addr    = s_addr;
            have_prev = 1'b1;
            step();
        end
        check("rnd_frames", 32'(frames), 8);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
